m_alu_arbiter: RTL and testbench
================================

Name: m_alu_arbiter

Overview:
Shares one combinational ALU (32-bit, 4-bit selector) between two requesters, port 0 and port 1. Each port uses a valid/ready request and response handshake. Operands are registered before the ALU and the result is registered after it. The block also flags unsupported opcodes and keeps a saturating count of completed operations per port. It sits between the multi-cycle control path and the shared ALU instance.

Parameters:
CNT_W, 16, width of each per-port completed-operation counter
INIT_PRIO, 0, port that holds round-robin priority after reset (0 or 1)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  2  per-port request valid; bit i = port i
req_ready  out  2  per-port request accepted this cycle
req_a0, req_a1  in  32  first operand, port 0 / port 1
req_b0, req_b1  in  32  second operand, port 0 / port 1
req_sel0, req_sel1  in  4  ALU selector, port 0 / port 1
rsp_valid  out  2  per-port response valid
rsp_ready  in  2  per-port response consumed
rsp_result  out  32  result register, shared by both ports
rsp_zero  out  1  registered zero flag
rsp_illegal  out  1  selector was not a supported opcode
busy  out  1  high whenever the FSM is not in IDLE
cnt0, cnt1  out  CNT_W  saturating completed-operation counters

Behaviour:
- Reset is synchronous and active-high; there is a single clock, clk.
- Reset values: state=IDLE; req_ready=0; rsp_valid=0; rsp_result=0; rsp_zero=0; rsp_illegal=0; busy=0; cnt0=cnt1=0; priority=INIT_PRIO.
- FSM states:
  - IDLE: at most one req_ready bit may be high. It is driven combinationally from req_valid and priority; a lone valid port wins, and if both are valid the priority port wins. When req_valid[i] & req_ready[i]: capture a, b, sel and the owner id i, flip priority to the other port, go to EXEC.
  - EXEC: one cycle. The registered operands drive the ALU. Capture result, zero and illegal into the rsp registers. Go to RESP.
  - RESP: rsp_valid[owner]=1; the other rsp_valid bit stays 0. rsp_result, rsp_zero and rsp_illegal hold steady until rsp_ready[owner]. On that handshake: increment cnt_owner, saturating at 2^CNT_W-1 (no wrap). Go to IDLE. rsp_ready on the non-owner port is ignored.
- req_ready=0 in EXEC and RESP. A request held valid during RESP is granted no earlier than the IDLE cycle after the response handshake.
- Latency: accept at cycle N gives rsp_valid at N+2. Minimum issue interval is 3 cycles, with rsp_ready tied high.
- Fairness: with both ports continuously valid, grants strictly alternate.
- Supported selectors: 0000 AND, 0001 OR, 0010 add (mod 2^32), 0110 sub (mod 2^32), 0111 slt (unsigned, result 0 or 1), 1100 NOR (bitwise ~(a|b)).
  - Any other selector: the operation still completes with result=0, zero=1, illegal=1.
- Zero flag: rsp_zero = (result == 0).
- Reset during EXEC or RESP: the in-flight operation is discarded, no response is issued, and counters clear.
- Changing req_* inputs after acceptance has no effect on the operation in flight.

Decomposition:
- Shared package m_alu_pkg holds:
  - opcode localparams AND/OR/ADD/SUB/SLT/NOR;
  - the FSM state encoding IDLE/EXEC/RESP;
  - a function is_legal_sel(sel).
- One sub-module is natural: the shared 32-bit combinational ALU, instantiated once inside the arbiter with registered operands and selector.
- Arbitration and the counters stay inline.

Test Plan:
- Port 0 only, a=5, b=3, sel=0010, rsp_ready=1 -> rsp_valid=2'b01 two cycles after accept; result=8, zero=0, illegal=0, cnt0=1.
- Both ports valid every cycle, INIT_PRIO=0; port 0 issues sub 7-7, port 1 issues slt 1<2 -> grants in order 0,1,0,1. Port 0 results: 0 with zero=1. Port 1 results: 1 with zero=0.
- rsp_ready held low 5 cycles after a port 1 NOR of a=0, b=0 -> rsp_valid[1] and result=32'hFFFF_FFFF stay stable; req_ready=0 throughout; port 0 request waits.
- sel=1111 from port 1 -> result=0, zero=1, illegal=1; cnt1 increments.
- Reset asserted while in EXEC -> next cycle all outputs are at reset values and no rsp_valid pulse occurs. A new request afterwards completes normally.
- CNT_W=2 with 5 completions on port 0 -> cnt0 sequence 1,2,3,3,3.

Source files
------------

// File: rtl/m_alu_pkg.sv
// -----------------------------------------------------------------------------
// m_alu_pkg
// Shared definitions for the ALU arbiter slice:
//   - 4-bit ALU selector encodings for the supported operations
//   - arbiter FSM state encoding
//   - is_legal_sel(): 1 when a selector names a supported operation
// -----------------------------------------------------------------------------
package m_alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;

    localparam logic [SEL_W-1:0] SEL_AND = 4'b0000;
    localparam logic [SEL_W-1:0] SEL_OR  = 4'b0001;
    localparam logic [SEL_W-1:0] SEL_ADD = 4'b0010;
    localparam logic [SEL_W-1:0] SEL_SUB = 4'b0110;
    localparam logic [SEL_W-1:0] SEL_SLT = 4'b0111;
    localparam logic [SEL_W-1:0] SEL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_legal_sel(input logic [SEL_W-1:0] sel);
        logic legal;
        case (sel)
            SEL_AND, SEL_OR, SEL_ADD, SEL_SUB, SEL_SLT, SEL_NOR: legal = 1'b1;
            default:                                             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/m_alu_arbiter_alu.sv
// -----------------------------------------------------------------------------
// m_alu_arbiter_alu
// Purely combinational 32-bit ALU shared by both arbiter ports.
// Ports:
//   a, b     in  32  operands
//   sel      in  4   operation selector
//   result   out 32  operation result (0 for unsupported selectors)
//   zero     out 1   result == 0
//   illegal  out 1   selector is not a supported operation
// -----------------------------------------------------------------------------
module m_alu_arbiter_alu
    import m_alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              illegal
);

    always_comb begin
        result  = '0;
        illegal = ~is_legal_sel(sel);
        case (sel)
            SEL_AND: result = a & b;
            SEL_OR:  result = a | b;
            SEL_ADD: result = a + b;
            SEL_SUB: result = a - b;
            // Unsigned compare, result is 0 or 1.
            SEL_SLT: result = {{(DATA_W-1){1'b0}}, (a < b)};
            SEL_NOR: result = ~(a | b);
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/m_alu_arbiter.sv
// -----------------------------------------------------------------------------
// m_alu_arbiter
// Round-robin arbiter sharing one ALU between two requesters. Operands are
// registered on acceptance, the ALU result is registered one cycle later and
// held on the response port until the owning requester consumes it.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_valid/req_ready [2]  request handshake, bit i = port i
//   req_a*/req_b*/req_sel*   operands and selector for port 0 / port 1
//   rsp_valid/rsp_ready [2]  response handshake, only the owner bit is used
//   rsp_result/zero/illegal  registered ALU outputs, shared by both ports
//   busy                     FSM is not idle
//   cnt0, cnt1               saturating completed-operation counters
// -----------------------------------------------------------------------------
module m_alu_arbiter
    import m_alu_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int INIT_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [SEL_W-1:0]  req_sel0,
    input  logic [SEL_W-1:0]  req_sel1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_illegal,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    localparam logic             PRIO_RST = (INIT_PRIO != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t              state_q, state_d;
    logic                prio_q;
    logic                owner_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [SEL_W-1:0]    sel_q;
    logic [DATA_W-1:0]   result_q;
    logic                zero_q, illegal_q;
    logic [CNT_W-1:0]    cnt_q [2];

    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero, alu_illegal;

    // Arbitration: a lone valid port wins; on contention the priority port wins.
    logic                grant_id;
    logic                accept;
    logic                rsp_hs;

    always_comb begin
        case (req_valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            default: grant_id = prio_q;
        endcase
    end

    assign accept = (state_q == ST_IDLE) && (|req_valid);
    assign rsp_hs = (state_q == ST_RESP) && rsp_ready[owner_q];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_hs) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: if (accept) req_ready[grant_id] = 1'b1;
            ST_RESP: rsp_valid[owner_q] = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q    <= PRIO_RST;
            owner_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                owner_q <= grant_id;
                prio_q  <= ~grant_id;
                a_q     <= grant_id ? req_a1   : req_a0;
                b_q     <= grant_id ? req_b1   : req_b0;
                sel_q   <= grant_id ? req_sel1 : req_sel0;
            end
            if (state_q == ST_EXEC) begin
                result_q  <= alu_result;
                zero_q    <= alu_zero;
                illegal_q <= alu_illegal;
            end
        end
    end

    m_alu_arbiter_alu u_alu (
        .a       (a_q),
        .b       (b_q),
        .sel     (sel_q),
        .result  (alu_result),
        .zero    (alu_zero),
        .illegal (alu_illegal)
    );

    // ---------------- Per-port saturating completion counters ----------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            localparam logic PORT_ID = (gi != 0);
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q[gi] <= '0;
                end else if (rsp_hs && (owner_q == PORT_ID) && (cnt_q[gi] != CNT_MAX)) begin
                    cnt_q[gi] <= cnt_q[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign cnt0        = cnt_q[0];
    assign cnt1        = cnt_q[1];
    assign rsp_result  = result_q;
    assign rsp_zero    = zero_q;
    assign rsp_illegal = illegal_q;

endmodule

// File: tb/tb_m_alu_arbiter.sv
module tb_m_alu_arbiter;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [31:0]      req_a0, req_a1, req_b0, req_b1;
    logic [3:0]       req_sel0, req_sel1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_zero, rsp_illegal, busy;
    logic [CNT_W-1:0] cnt0, cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    m_alu_arbiter #(.CNT_W(CNT_W), .INIT_PRIO(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a0      (req_a0),
        .req_a1      (req_a1),
        .req_b0      (req_b0),
        .req_b1      (req_b1),
        .req_sel0    (req_sel0),
        .req_sel1    (req_sel1),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal),
        .busy        (busy),
        .cnt0        (cnt0),
        .cnt1        (cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_result"},    64'(rsp_result), 64'd0);
        chk({tag, "_zero"},      64'(rsp_zero), 64'd0);
        chk({tag, "_illegal"},   64'(rsp_illegal), 64'd0);
        chk({tag, "_busy"},      64'(busy), 64'd0);
        chk({tag, "_cnt0"},      64'(cnt0), 64'd0);
        chk({tag, "_cnt1"},      64'(cnt1), 64'd0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One operation from a single port with rsp_ready high: checks acceptance,
    // the two-cycle latency, the response fields and the owner's counter.
    task automatic run_op(input string tag, input int port, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] sel,
                          input logic [31:0] exp_r, input logic exp_z,
                          input logic exp_il, input logic [CNT_W-1:0] exp_cnt);
        logic [1:0] pbit;
        pbit = (port == 0) ? 2'b01 : 2'b10;
        if (port == 0) begin req_a0 = a; req_b0 = b; req_sel0 = sel; end
        else           begin req_a1 = a; req_b1 = b; req_sel1 = sel; end
        req_valid = pbit;
        rsp_ready = 2'b11;
        #1;
        chk({tag, "_accept"}, 64'(req_ready), 64'(pbit));
        tick();
        // Operands change after acceptance; the operation in flight must not care.
        req_valid = 2'b00;
        req_a0 = 32'hDEAD_BEEF; req_b0 = 32'h1234_5678; req_sel0 = 4'b0001;
        req_a1 = 32'hDEAD_BEEF; req_b1 = 32'h1234_5678; req_sel1 = 4'b0001;
        #1;
        chk({tag, "_exec_busy"}, 64'(busy), 64'd1);
        chk({tag, "_exec_rspv"}, 64'(rsp_valid), 64'd0);
        tick();
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(pbit));
        chk({tag, "_result"},    64'(rsp_result), 64'(exp_r));
        chk({tag, "_zero"},      64'(rsp_zero), 64'(exp_z));
        chk({tag, "_illegal"},   64'(rsp_illegal), 64'(exp_il));
        tick();
        chk({tag, "_idle_rspv"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_cnt"},       64'((port == 0) ? cnt0 : cnt1), 64'(exp_cnt));
        $display("op %s port=%0d a=%08h b=%08h sel=%04b -> result=%08h zero=%0b illegal=%0b cnt0=%0d cnt1=%0d",
                 tag, port, a, b, sel, rsp_result, rsp_zero, rsp_illegal, cnt0, cnt1);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        req_sel0 = '0; req_sel1 = '0;

        // ---------------- Reset state ----------------
        do_reset();
        check_reset_state("rst");

        // ---------------- Single port 0 add ----------------
        run_op("add5p3", 0, 32'd5, 32'd3, 4'b0010, 32'd8, 1'b0, 1'b0, 2'd1);

        // ---------------- Fairness: both ports valid continuously ----------------
        do_reset();
        req_a0 = 32'd7; req_b0 = 32'd7; req_sel0 = 4'b0110;
        req_a1 = 32'd1; req_b1 = 32'd2; req_sel1 = 4'b0111;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic [1:0]  exp_g;
            logic [31:0] exp_r;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_r = (i % 2 == 0) ? 32'd0 : 32'd1;
            #1;
            chk("fair_grant", 64'(req_ready), 64'(exp_g));
            tick();
            chk("fair_exec_ready", 64'(req_ready), 64'd0);
            tick();
            chk("fair_rsp_valid", 64'(rsp_valid), 64'(exp_g));
            chk("fair_result",    64'(rsp_result), 64'(exp_r));
            chk("fair_zero",      64'(rsp_zero), 64'((i % 2 == 0) ? 1 : 0));
            chk("fair_resp_ready", 64'(req_ready), 64'd0);
            $display("fair op %0d grant=%02b result=%08h zero=%0b", i, exp_g, rsp_result, rsp_zero);
            tick();
        end
        req_valid = 2'b00;
        #1;
        chk("fair_cnt0", 64'(cnt0), 64'd2);
        chk("fair_cnt1", 64'(cnt1), 64'd2);

        // ---------------- Illegal selector on port 1 ----------------
        run_op("illegal", 1, 32'h0000_00FF, 32'h0000_0001, 4'b1111, 32'd0, 1'b1, 1'b1, 2'd3);

        // ---------------- Response stall: port 1 NOR, port 0 waits ----------------
        req_a1 = 32'd0; req_b1 = 32'd0; req_sel1 = 4'b1100;
        req_a0 = 32'h0000_F0F0; req_b0 = 32'h0000_FF00; req_sel0 = 4'b0000;
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        #1;
        chk("stall_grant1", 64'(req_ready), 64'd2);
        tick();
        req_valid = 2'b11;
        tick();
        for (int i = 0; i < 5; i++) begin
            // Non-owner ready must not complete the response.
            rsp_ready = (i == 2) ? 2'b01 : 2'b00;
            #1;
            chk("stall_rsp_valid", 64'(rsp_valid), 64'd2);
            chk("stall_result",    64'(rsp_result), 64'hFFFF_FFFF);
            chk("stall_zero",      64'(rsp_zero), 64'd0);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            $display("stall cycle %0d rsp_valid=%02b result=%08h", i, rsp_valid, rsp_result);
            tick();
        end
        rsp_ready = 2'b10;
        #1;
        chk("stall_hs_ready", 64'(req_ready), 64'd0);
        tick();
        rsp_ready = 2'b11;
        #1;
        chk("stall_cnt1_sat", 64'(cnt1), 64'd3);
        chk("stall_p0_grant", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        tick();
        chk("stall_p0_result", 64'(rsp_result), 64'h0000_F000);
        chk("stall_p0_rspv",   64'(rsp_valid), 64'd1);
        tick();
        chk("stall_p0_cnt0", 64'(cnt0), 64'd3);

        // ---------------- Reset while in EXEC ----------------
        req_a0 = 32'd9; req_b0 = 32'd1; req_sel0 = 4'b0010;
        req_valid = 2'b01;
        #1;
        chk("rexec_accept", 64'(req_ready), 64'd1);
        tick();
        chk("rexec_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        req_valid = 2'b00;
        tick();
        reset = 1'b0;
        check_reset_state("rexec");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rexec_no_rsp", 64'(rsp_valid), 64'd0);
        end
        $display("reset in EXEC: rsp_valid=%02b busy=%0b cnt0=%0d cnt1=%0d", rsp_valid, busy, cnt0, cnt1);

        // ---------------- Saturation: 5 port-0 completions after reset ----------------
        run_op("sat_or",   0, 32'hA0A0_0000, 32'h0000_0505, 4'b0001, 32'hA0A0_0505, 1'b0, 1'b0, 2'd1);
        run_op("sat_addw", 0, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 32'd0,         1'b1, 1'b0, 2'd2);
        run_op("sat_subw", 0, 32'd3,         32'd5,         4'b0110, 32'hFFFF_FFFE, 1'b0, 1'b0, 2'd3);
        run_op("sat_slt",  0, 32'h8000_0000, 32'd1,         4'b0111, 32'd0,         1'b1, 1'b0, 2'd3);
        run_op("sat_nor",  0, 32'hFFFF_0000, 32'h0000_00FF, 4'b1100, 32'h0000_FF00, 1'b0, 1'b0, 2'd3);
        chk("sat_cnt1", 64'(cnt1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
